// File: rtl/sync_filter_edge.sv
// sync_filter_edge: per-channel input synchroniser, glitch filter, edge/event pulses and sticky event flags
module sync_filter_edge #(
   parameter int              NCH     = 8,
   parameter int              DP      = 2,
   parameter int              FLT     = 4,
   parameter logic [NCH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   din_a,
   input  logic [2*NCH-1:0] mode,
   input  logic [NCH-1:0]   clr,
   output logic [NCH-1:0]   lvl,
   output logic [NCH-1:0]   rise,
   output logic [NCH-1:0]   fall,
   output logic [NCH-1:0]   evt,
   output logic [NCH-1:0]   sticky
);

   localparam int CW = $clog2(FLT + 1);

   if (DP < 2) begin : g_bad_dp
      $error("sync_filter_edge: DP must be >= 2");
   end
   if (FLT < 1 || FLT > 255) begin : g_bad_flt
      $error("sync_filter_edge: FLT must be in 1..255");
   end

   logic [DP-1:0][NCH-1:0] r_sync;
   logic [NCH-1:0]         w_s;
   logic [NCH-1:0]         w_acc;
   logic [NCH-1:0]         w_evt;
   logic [NCH-1:0]         r_lvl;
   logic [NCH-1:0]         r_rise;
   logic [NCH-1:0]         r_fall;
   logic [NCH-1:0]         r_evt;
   logic [NCH-1:0]         r_sticky;
   logic [CW-1:0]          r_cnt [NCH];

   assign w_s    = r_sync[DP-1];
   assign lvl    = r_lvl;
   assign rise   = r_rise;
   assign fall   = r_fall;
   assign evt    = r_evt;
   assign sticky = r_sticky;

   // plain flop chain bringing the asynchronous inputs into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= {DP{RST_VAL}};
      else        r_sync <= {r_sync[DP-2:0], din_a};
   end

   // accept when the mismatch run reaches FLT cycles; event when the accepted edge matches mode
   always_comb begin
      w_acc = '0;
      w_evt = '0;
      for (int c = 0; c < NCH; c++) begin
         w_acc[c] = (w_s[c] != r_lvl[c]) && (r_cnt[c] == CW'(FLT - 1));
         w_evt[c] = w_acc[c] & (w_s[c] ? mode[2*c] : mode[2*c+1]);
      end
   end

   // filter counters, filtered level, edge/event pulses and sticky flags (set beats clear)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) r_cnt[c] <= '0;
         r_lvl    <= RST_VAL;
         r_rise   <= '0;
         r_fall   <= '0;
         r_evt    <= '0;
         r_sticky <= '0;
      end else begin
         for (int c = 0; c < NCH; c++)
            r_cnt[c] <= (w_s[c] == r_lvl[c] || w_acc[c]) ? '0 : r_cnt[c] + CW'(1);
         r_lvl    <= (r_lvl & ~w_acc) | (w_s & w_acc);
         r_rise   <= w_acc & w_s;
         r_fall   <= w_acc & ~w_s;
         r_evt    <= w_evt;
         r_sticky <= w_evt | (r_sticky & ~clr);
      end
   end

endmodule

// File: tb/tb_sync_filter_edge.sv
// tb_sync_filter_edge: directed table-driven check of sync_filter_edge (NCH=8, DP=2, FLT=4, RST_VAL=8'h0F)
module tb_sync_filter_edge;

   localparam int         NCH = 8;
   localparam int         DP  = 2;
   localparam int         FLT = 4;
   localparam logic [7:0] RV  = 8'h0F;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  din_a = RV;
   logic [15:0] mode  = '0;
   logic [7:0]  clr   = '0;
   logic [7:0]  lvl, rise, fall, evt, sticky;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          n;
      logic [7:0]  din;
      logic [15:0] mode;
      logic [7:0]  clr;
      logic [7:0]  lvl;
      logic [7:0]  rise;
      logic [7:0]  fall;
      logic [7:0]  evt;
      logic [7:0]  sticky;
   } vec_t;

   vec_t tbl[$];

   sync_filter_edge #(.NCH(NCH), .DP(DP), .FLT(FLT), .RST_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .din_a(din_a), .mode(mode), .clr(clr),
      .lvl(lvl), .rise(rise), .fall(fall), .evt(evt), .sticky(sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic chk_all(input int idx, input logic [7:0] l, input logic [7:0] r, input logic [7:0] f,
                          input logic [7:0] e, input logic [7:0] s);
      chk("lvl", idx, lvl, l);
      chk("rise", idx, rise, r);
      chk("fall", idx, fall, f);
      chk("evt", idx, evt, e);
      chk("sticky", idx, sticky, s);
   endtask

   task automatic step(input logic [7:0] d, input logic [15:0] m, input logic [7:0] c);
      @(negedge clk);
      din_a = d;
      mode  = m;
      clr   = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // all channels 0..3 drop to 0 together: simultaneous falls
      tbl.push_back('{5, 8'h00, 16'h0000, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00});
      // latency on ch0: rise exactly at edge DP+FLT
      tbl.push_back('{5, 8'h01, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h01, 16'h0000, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{2, 8'h01, 16'h0000, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{5, 8'h00, 16'h0000, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00});
      // ch3 glitch of 3 cycles rejected, 4 cycles accepted then falls
      tbl.push_back('{3, 8'h08, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{7, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{4, 8'h08, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0000, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{3, 8'h00, 16'h0000, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00});
      // modes: ch1 rise, ch2 fall, ch3 both, ch4 none
      tbl.push_back('{5, 8'h1E, 16'h00E4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h1E, 16'h00E4, 8'h00, 8'h1E, 8'h1E, 8'h00, 8'h0A, 8'h0A});
      tbl.push_back('{2, 8'h1E, 16'h00E4, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h0A});
      tbl.push_back('{5, 8'h00, 16'h00E4, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h0A});
      tbl.push_back('{1, 8'h00, 16'h00E4, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h0C, 8'h0E});
      tbl.push_back('{1, 8'h00, 16'h00E4, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      // sticky on ch5: set, hold, clear, then set and clear on the same edge
      tbl.push_back('{5, 8'h20, 16'h0400, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h20, 16'h0400, 8'h00, 8'h20, 8'h20, 8'h00, 8'h20, 8'h20});
      tbl.push_back('{3, 8'h20, 16'h0400, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20});
      tbl.push_back('{1, 8'h20, 16'h0400, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{5, 8'h00, 16'h0C00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1, 8'h00, 16'h0C00, 8'h20, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20});
      tbl.push_back('{2, 8'h00, 16'h0C00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20});
      tbl.push_back('{1, 8'h00, 16'h0C00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all(-1, RV, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      // quiet release: inputs equal to reset value give no pulses
      for (int k = 0; k < 20; k++) begin
         step(RV, 16'h0000, 8'h00);
         chk_all(1000 + k, RV, 8'h00, 8'h00, 8'h00, 8'h00);
      end

      for (int r = 0; r < tbl.size(); r++)
         for (int k = 0; k < tbl[r].n; k++) begin
            step(tbl[r].din, tbl[r].mode, tbl[r].clr);
            chk_all(r, tbl[r].lvl, tbl[r].rise, tbl[r].fall, tbl[r].evt, tbl[r].sticky);
         end

      // ch7 toggling every cycle never gets through the filter
      for (int k = 0; k < 12; k++) begin
         step((k % 2 == 0) ? 8'h80 : 8'h00, 16'hFFFF, 8'h00);
         chk_all(2000 + k, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      end
      for (int k = 0; k < 3; k++) begin
         step(8'h00, 16'h0000, 8'h00);
         chk_all(2100 + k, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      end

      // ch6 two cycles into the filter, then reset mid-count
      for (int k = 0; k < 4; k++) begin
         step(8'h40, 16'h0000, 8'h00);
         chk_all(3000 + k, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all(3100, RV, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      // after release ch6 rises and ch0..3 fall at edge DP+FLT
      for (int k = 1; k <= DP + FLT; k++) begin
         @(posedge clk);
         #1;
         if (k < DP + FLT) chk_all(3200 + k, RV, 8'h00, 8'h00, 8'h00, 8'h00);
         else              chk_all(3200 + k, 8'h40, 8'h40, 8'h0F, 8'h00, 8'h00);
      end
      step(8'h40, 16'h0000, 8'h00);
      chk_all(3300, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
